adc_capture_ctrl: RTL and testbench

//  Sequences capture of deserialized 14-bit ADC samples into a sample buffer RAM.

---
 rtl/adc_ctrl_pkg.sv | 16 +
 rtl/adc_capture_ctrl_if.sv | 24 ++
 rtl/adc_trig_detect.sv | 61 ++++++
 rtl/adc_capture_ctrl.sv | 133 +++++++++++++
 tb/tb_adc_capture_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_ctrl_pkg.sv
// rtl/adc_ctrl_pkg.sv - shared state encoding and trigger mode constants for the ADC capture controller
package adc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_SOFTWARE  = 2'd1;
    localparam logic [1:0] TRIG_RISING    = 2'd2;
    localparam logic [1:0] TRIG_FALLING   = 2'd3;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// rtl/adc_capture_ctrl_if.sv - sample stream in and buffer write port out of the capture controller
interface adc_capture_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14
) ();
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              buf_ready;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;

    // Controller side: consumes samples, drives buffer writes.
    modport master (
        input  adc_data, adc_valid, buf_ready,
        output buf_we, buf_addr, buf_wdata
    );

    // Environment side: deserializer plus sample buffer.
    modport slave (
        output adc_data, adc_valid, buf_ready,
        input  buf_we, buf_addr, buf_wdata
    );
endinterface

// File: rtl/adc_trig_detect.sv
// rtl/adc_trig_detect.sv - trigger qualification: immediate, software, rising or falling level crossing
module adc_trig_detect
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              armed_i,
    input  logic              sw_trig_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              trig_o
);

    logic [DATA_W-1:0] prev_q;
    logic              prev_vld_q;
    logic              sw_seen_q;
    logic              prev_below;
    logic              cur_below;
    logic              hit;

    // Track the last valid sample seen while armed and latch a software trigger pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            sw_seen_q  <= 1'b0;
        end else if (clr_i) begin
            prev_vld_q <= 1'b0;
            sw_seen_q  <= 1'b0;
        end else begin
            if (armed_i && valid_i) begin
                prev_q     <= data_i;
                prev_vld_q <= 1'b1;
            end
            if (armed_i && sw_trig_i) begin
                sw_seen_q <= 1'b1;
            end
        end
    end

    // Level crossings need a previous sample captured since arm; mode/level are used live.
    always_comb begin
        prev_below = (prev_q < level_i);
        cur_below  = (data_i < level_i);
        hit        = 1'b0;
        case (mode_i)
            TRIG_IMMEDIATE: hit = 1'b1;
            TRIG_SOFTWARE:  hit = sw_trig_i | sw_seen_q;
            TRIG_RISING:    hit = prev_vld_q & prev_below & ~cur_below;
            TRIG_FALLING:   hit = prev_vld_q & ~prev_below & cur_below;
            default:        hit = 1'b0;
        endcase
        trig_o = armed_i & valid_i & hit;
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - arm/trigger/capture sequencer writing ADC samples into the sample buffer
module adc_capture_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_arm,
    input  logic                 cfg_abort,
    input  logic [1:0]           cfg_trig_mode,
    input  logic                 cfg_sw_trig,
    input  logic [DATA_W-1:0]    cfg_level,
    input  logic [ADDR_W-1:0]    cfg_len,
    adc_capture_ctrl_if.master   bus,
    output logic                 sts_armed,
    output logic                 sts_busy,
    output logic                 sts_done,
    output logic                 sts_overrun,
    output logic [ADDR_W:0]      sts_count,
    output logic                 irq
);

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W:0]   eff_len;
    logic              buf_we_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [DATA_W-1:0] buf_wdata_q;
    logic              done_q;
    logic              overrun_q;
    logic              irq_q;
    logic              arm_ok;
    logic              trig;
    logic              in_window;
    logic              accept;
    logic              drop;

    // Abort outranks arm, and arm only restarts from IDLE or DONE.
    always_comb begin
        arm_ok    = cfg_arm & ~cfg_abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        eff_len   = (cfg_len == '0) ? FULL_LEN : {1'b0, cfg_len};
        count_inc = count_q + 1'b1;
        in_window = ((state_q == ST_ARMED) & trig) | ((state_q == ST_CAPTURE) & bus.adc_valid);
        accept    = in_window & bus.buf_ready & ~cfg_abort;
        drop      = in_window & ~bus.buf_ready & ~cfg_abort;
    end

    adc_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (arm_ok),
        .armed_i   (state_q == ST_ARMED),
        .sw_trig_i (cfg_sw_trig),
        .mode_i    (cfg_trig_mode),
        .level_i   (cfg_level),
        .data_i    (bus.adc_data),
        .valid_i   (bus.adc_valid),
        .trig_o    (trig)
    );

    // Sequencer, write register stage and sticky status; a completing write overrides the CAPTURE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            len_q       <= '0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            buf_we_q <= 1'b0;
            irq_q    <= 1'b0;
            if (cfg_abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm_ok) begin
                            state_q   <= ST_ARMED;
                            done_q    <= 1'b0;
                            overrun_q <= 1'b0;
                            count_q   <= '0;
                            len_q     <= eff_len;
                        end
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        state_q <= ST_CAPTURE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
                if (accept) begin
                    buf_we_q    <= 1'b1;
                    buf_addr_q  <= count_q[ADDR_W-1:0];
                    buf_wdata_q <= bus.adc_data;
                    count_q     <= count_inc;
                    if (count_inc == len_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                    end
                end
                if (drop) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.buf_we    = buf_we_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign sts_armed     = (state_q == ST_ARMED);
    assign sts_busy      = (state_q == ST_ARMED) | (state_q == ST_CAPTURE);
    assign sts_done      = done_q;
    assign sts_overrun   = overrun_q;
    assign sts_count     = count_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - scoreboard bench for adc_capture_ctrl with directed vectors
module tb_adc_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_arm = 1'b0;
    logic              cfg_abort = 1'b0;
    logic [1:0]        cfg_trig_mode = 2'd0;
    logic              cfg_sw_trig = 1'b0;
    logic [DATA_W-1:0] cfg_level = '0;
    logic [ADDR_W-1:0] cfg_len = '0;
    logic              sts_armed;
    logic              sts_busy;
    logic              sts_done;
    logic              sts_overrun;
    logic [ADDR_W:0]   sts_count;
    logic              irq;

    adc_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    adc_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_arm       (cfg_arm),
        .cfg_abort     (cfg_abort),
        .cfg_trig_mode (cfg_trig_mode),
        .cfg_sw_trig   (cfg_sw_trig),
        .cfg_level     (cfg_level),
        .cfg_len       (cfg_len),
        .bus           (bus.master),
        .sts_armed     (sts_armed),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_overrun   (sts_overrun),
        .sts_count     (sts_count),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int irq_cnt = 0;
    int wr_cnt = 0;
    logic [ADDR_W-1:0]        last_addr = '0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        sine[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int a, input int d);
        exp_q.push_back({a[ADDR_W-1:0], d[DATA_W-1:0]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] m, input logic [ADDR_W-1:0] l, input logic [DATA_W-1:0] lv);
        cfg_trig_mode = m;
        cfg_len       = l;
        cfg_level     = lv;
        cfg_arm       = 1'b1;
        tick();
        cfg_arm = 1'b0;
        wr_cnt  = 0;
        irq_cnt = 0;
    endtask

    task automatic send(input int d, input logic v, input logic r);
        bus.adc_data  = d[DATA_W-1:0];
        bus.adc_valid = v;
        bus.buf_ready = r;
        tick();
    endtask

    task automatic settle();
        bus.adc_valid = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: every buffer write is matched against the oldest expected entry.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (!rst) begin
            if (bus.buf_we) begin
                wr_cnt++;
                last_addr = bus.buf_addr;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write",
                             bus.buf_addr, bus.buf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(bus.buf_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    check("write_data", 32'(bus.buf_wdata), 32'(e[DATA_W-1:0]));
                end
            end
            if (irq) begin
                irq_cnt++;
                check("irq_with_last_we", 32'(bus.buf_we), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int tmp;
        for (int i = 0; i < 64; i++) begin
            tmp = $rtoi(8191.5 + 8191.5 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.4999);
            sine[i] = tmp[DATA_W-1:0];
        end
        bus.adc_data  = '0;
        bus.adc_valid = 1'b0;
        bus.buf_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.buf_we, bus.buf_addr, bus.buf_wdata, sts_armed, sts_busy,
                                    sts_done, sts_overrun, sts_count, irq}), 32'd0);
        rst = 1'b0;
        tick();

        // Immediate trigger, cfg_len=0 means full 16-deep buffer
        arm(2'd0, 4'd0, 14'd0);
        check("armed_after_arm", 32'({sts_armed, sts_busy}), 32'b11);
        check("no_we_before_sample", 32'(bus.buf_we), 32'd0);
        for (int i = 0; i < 16; i++) push_exp(i, 'h100 + i);
        send('h100, 1'b1, 1'b1);
        check("first_we_latency", 32'({bus.buf_we, bus.buf_addr}), 32'b10000);
        for (int i = 1; i < 20; i++) send('h100 + i, 1'b1, 1'b1);
        settle();
        check("m0_done", 32'(sts_done), 32'd1);
        check("m0_count", 32'(sts_count), 32'd16);
        check("m0_irq_pulses", irq_cnt, 32'd1);
        check("m0_writes", wr_cnt, 32'd16);
        check("m0_last_addr", 32'(last_addr), 32'd15);
        check("m0_not_busy", 32'({sts_busy, sts_overrun}), 32'd0);
        check("m0_queue_empty", exp_q.size(), 32'd0);

        // Rising level crossing on a 64-point sine, starting at the positive peak
        arm(2'd2, 4'd8, 14'h2000);
        push_exp(0, 'h2322);
        for (int k = 1; k < 8; k++) push_exp(k, int'(sine[1 + k]));
        for (int j = 0; j < 64; j++) send(int'(sine[(16 + j) % 64]), 1'b1, 1'b1);
        settle();
        check("rise_done", 32'(sts_done), 32'd1);
        check("rise_count", 32'(sts_count), 32'd8);
        check("rise_irq_pulses", irq_cnt, 32'd1);
        check("rise_queue_empty", exp_q.size(), 32'd0);

        // Software trigger at cycle 50, valid resumes at 53
        arm(2'd1, 4'd4, 14'd0);
        for (int c = 0; c < 50; c++) send('h300 + c, 1'b1, 1'b1);
        check("sw_waiting", 32'({sts_armed, sts_busy, sts_done}), 32'b110);
        for (int c = 53; c < 57; c++) push_exp(c - 53, 'h300 + c);
        cfg_sw_trig = 1'b1;
        send('h300 + 50, 1'b0, 1'b1);
        cfg_sw_trig = 1'b0;
        send('h300 + 51, 1'b0, 1'b1);
        send('h300 + 52, 1'b0, 1'b1);
        for (int c = 53; c < 60; c++) send('h300 + c, 1'b1, 1'b1);
        settle();
        check("sw_done", 32'(sts_done), 32'd1);
        check("sw_count", 32'(sts_count), 32'd4);
        check("sw_irq_pulses", irq_cnt, 32'd1);
        check("sw_queue_empty", exp_q.size(), 32'd0);

        // Abort in DONE keeps sticky status
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_keeps_status", 32'({sts_armed, sts_busy, sts_done, sts_count}), 32'b00_1_00100);

        // Arm, abort back to IDLE, then abort+arm together: abort wins
        arm(2'd0, 4'd4, 14'd0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_from_armed", 32'({sts_armed, sts_busy, sts_done}), 32'd0);
        cfg_abort = 1'b1;
        cfg_arm   = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_arm   = 1'b0;
        check("abort_arm_idle", 32'({sts_armed, sts_busy, sts_done}), 32'd0);
        for (int i = 0; i < 6; i++) send('h400 + i, 1'b1, 1'b1);
        settle();
        check("abort_arm_no_capture", 32'({sts_done, sts_count}), 32'd0);

        // buf_ready low for 3 samples mid-capture
        arm(2'd0, 4'd8, 14'd0);
        begin
            int a;
            a = 0;
            for (int i = 0; i < 13; i++) begin
                if ((i < 3 || i > 5) && a < 8) begin
                    push_exp(a, 'h500 + i);
                    a++;
                end
            end
        end
        for (int i = 0; i < 13; i++) send('h500 + i, 1'b1, !(i >= 3 && i <= 5));
        settle();
        check("ovr_flag", 32'(sts_overrun), 32'd1);
        check("ovr_done", 32'(sts_done), 32'd1);
        check("ovr_count", 32'(sts_count), 32'd8);
        check("ovr_last_addr", 32'(last_addr), 32'd7);
        check("ovr_irq_pulses", irq_cnt, 32'd1);
        check("ovr_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a capture, then a normal re-arm
        arm(2'd0, 4'd0, 14'd0);
        for (int i = 0; i < 5; i++) push_exp(i, 'h600 + i);
        for (int i = 0; i < 5; i++) send('h600 + i, 1'b1, 1'b1);
        bus.adc_valid = 1'b0;
        check("busy_mid_capture", 32'({sts_busy, bus.buf_we}), 32'b11);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({bus.buf_we, bus.buf_addr, bus.buf_wdata, sts_armed, sts_busy,
                                          sts_done, sts_overrun, sts_count, irq}), 32'd0);
        #10;
        rst = 1'b0;
        tick();
        arm(2'd0, 4'd4, 14'd0);
        for (int i = 0; i < 4; i++) push_exp(i, 'h700 + i);
        for (int i = 0; i < 4; i++) send('h700 + i, 1'b1, 1'b1);
        settle();
        check("rearm_done", 32'({sts_done, sts_count}), 32'b1_00100);
        check("rearm_irq_pulses", irq_cnt, 32'd1);
        check("rearm_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
